// File: rtl/train_sequencer_if.sv
// train_sequencer_if: sample-memory and network bus; master drives mem_addr/net_i1/net_i2/net_target/net_step/net_update, slave returns mem_x1/mem_x2/mem_target/net_err
interface train_sequencer_if #(parameter int AW = 8);
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_x1;
  logic [31:0] mem_x2;
  logic [31:0] mem_target;
  logic [31:0] net_i1;
  logic [31:0] net_i2;
  logic [31:0] net_target;
  logic [31:0] net_step;
  logic net_update;
  logic [31:0] net_err;
  modport master (
    output mem_addr, net_i1, net_i2, net_target, net_step, net_update,
    input mem_x1, mem_x2, mem_target, net_err
  );
  modport slave (
    input mem_addr, net_i1, net_i2, net_target, net_step, net_update,
    output mem_x1, mem_x2, mem_target, net_err
  );
endinterface

// File: rtl/train_sequencer.sv
// train_sequencer: 2-3-1 perceptron training controller; ports clk/reset(active-low sync), start/abort, run config (n_samples/max_epochs/err_thresh/step_in), bus (memory+network), status busy/done/converged/epoch_cnt/epoch_err
module train_sequencer #(
  parameter int FWD_LAT = 3,
  parameter int BP_LAT = 2,
  parameter int AW = 8
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic abort,
  input logic [AW:0] n_samples,
  input logic [15:0] max_epochs,
  input logic [31:0] err_thresh,
  input logic [31:0] step_in,
  train_sequencer_if.master bus,
  output logic busy,
  output logic done,
  output logic converged,
  output logic [15:0] epoch_cnt,
  output logic [31:0] epoch_err
);
  typedef enum logic [3:0] {IDLE, FETCH, LOAD, FWD, ERR, BACK, UPD, EPOCH, DONE} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [AW-1:0] idx;
  logic [AW:0] n_lat;
  logic [15:0] max_lat;
  logic [31:0] thr_lat, step_lat, i1, i2, tgt;
  logic [31:0] abs_err, sum, sat;
  logic last, conv_hit, limit_hit;
  // |0x80000000| has no positive 32-bit form, so it clamps to the max
  assign abs_err = bus.net_err[31] ? ((bus.net_err == 32'h8000_0000) ? 32'h7fff_ffff : -bus.net_err) : bus.net_err;
  assign sum = epoch_err + abs_err;
  assign sat = sum[31] ? 32'h7fff_ffff : sum;
  assign last = {1'b0, idx} == n_lat - (AW+1)'(1);
  assign conv_hit = epoch_err < thr_lat;
  assign limit_hit = epoch_cnt + 16'd1 == max_lat;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? ((n_samples == '0 || max_epochs == '0) ? DONE : FETCH) : IDLE;
      FETCH: nxt = LOAD;
      LOAD: nxt = FWD;
      FWD: nxt = (cnt == 8'(FWD_LAT - 1)) ? ERR : FWD;
      ERR: nxt = BACK;
      BACK: nxt = (cnt == 8'(BP_LAT - 1)) ? UPD : BACK;
      UPD: nxt = last ? EPOCH : FETCH;
      EPOCH: nxt = (conv_hit || limit_hit) ? DONE : FETCH;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE && !abort;
    bus.net_update = state == UPD && !abort;
    bus.mem_addr = idx;
    bus.net_i1 = i1;
    bus.net_i2 = i2;
    bus.net_target = tgt;
    bus.net_step = step_lat;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      n_lat <= '0;
      max_lat <= '0;
      thr_lat <= '0;
      step_lat <= '0;
      i1 <= '0;
      i2 <= '0;
      tgt <= '0;
      epoch_cnt <= '0;
      epoch_err <= '0;
      converged <= 1'b0;
    end else begin
      cnt <= (nxt == state && (state == FWD || state == BACK)) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && start && !abort) begin
        n_lat <= n_samples;
        max_lat <= max_epochs;
        thr_lat <= err_thresh;
        step_lat <= step_in;
        idx <= '0;
        epoch_cnt <= '0;
        epoch_err <= '0;
        converged <= 1'b0;
      end
      if (!abort) begin
        if (state == LOAD) begin
          i1 <= bus.mem_x1;
          i2 <= bus.mem_x2;
          tgt <= bus.mem_target;
        end
        if (state == ERR) epoch_err <= sat;
        if (state == UPD && !last) idx <= idx + AW'(1);
        if (state == EPOCH) begin
          epoch_cnt <= epoch_cnt + 16'd1;
          converged <= conv_hit;
          if (!conv_hit && !limit_hit) begin
            epoch_err <= '0;
            idx <= '0;
          end
        end
      end
    end
  end
endmodule
